// File: rtl/pipelined_addsub.sv
// Pipelined add/subtract unit: operands are processed one CHUNK-bit slice per stage,
// with the inter-slice carry registered between stages and a valid/ready handshake.
module pipelined_addsub #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int STAGES = WIDTH / CHUNK;
  localparam int LAST   = STAGES - 1;

  if (STAGES < 1 || (WIDTH % CHUNK) != 0) begin : g_param_check
    $error("pipelined_addsub: WIDTH must be a non-zero multiple of CHUNK");
  end

  typedef logic [WIDTH-1:0] word_t;

  // Entry k holds the state leaving stage k: operand skew copies, partial result, carry.
  word_t             a_q   [STAGES];
  word_t             bp_q  [STAGES];
  word_t             res_q [STAGES];
  logic [STAGES-1:0] c_q;
  logic [STAGES-1:0] vld_q;
  logic              ovf_q;
  logic              zero_q;

  word_t             a_d   [STAGES];
  word_t             bp_d  [STAGES];
  word_t             res_d [STAGES];
  logic [STAGES-1:0] c_d;
  logic [STAGES-1:0] vld_d;
  logic              ovf_d;
  logic              zero_d;

  logic              adv;

  function automatic logic [CHUNK:0] add_slice(input logic [CHUNK-1:0] x,
                                               input logic [CHUNK-1:0] y,
                                               input logic             ci);
    return {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, ci};
  endfunction

  always_comb begin
    // Stage 0: invert B for subtract and inject the initial carry.
    a_d[0]   = a;
    bp_d[0]  = sub ? ~b : b;
    res_d[0] = '0;
    {c_d[0], res_d[0][CHUNK-1:0]} = add_slice(a[CHUNK-1:0], bp_d[0][CHUNK-1:0],
                                              sub ? 1'b1 : cin);
    vld_d[0] = in_valid;

    // Stages 1..LAST: add the next slice using the carry registered by the previous stage.
    for (int k = 1; k < STAGES; k++) begin
      a_d[k]   = a_q[k-1];
      bp_d[k]  = bp_q[k-1];
      res_d[k] = res_q[k-1];
      {c_d[k], res_d[k][k*CHUNK +: CHUNK]} = add_slice(a_q[k-1][k*CHUNK +: CHUNK],
                                                       bp_q[k-1][k*CHUNK +: CHUNK],
                                                       c_q[k-1]);
      vld_d[k] = vld_q[k-1];
    end

    // Flags are formed from the final stage result so they land with sum.
    zero_d = (res_d[LAST] == '0);
    ovf_d  = (a_d[LAST][WIDTH-1] == bp_d[LAST][WIDTH-1]) &&
             (res_d[LAST][WIDTH-1] != a_d[LAST][WIDTH-1]);
  end

  // The whole pipe, bubbles included, moves only when the output slot is free or draining.
  assign adv = !vld_q[LAST] || out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        a_q[k]   <= '0;
        bp_q[k]  <= '0;
        res_q[k] <= '0;
      end
      c_q    <= '0;
      vld_q  <= '0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else if (adv) begin
      for (int k = 0; k < STAGES; k++) begin
        a_q[k]   <= a_d[k];
        bp_q[k]  <= bp_d[k];
        res_q[k] <= res_d[k];
      end
      c_q    <= c_d;
      vld_q  <= vld_d;
      ovf_q  <= ovf_d;
      zero_q <= zero_d;
    end
  end

  assign in_ready  = adv;
  assign out_valid = vld_q[LAST];
  assign sum       = res_q[LAST];
  assign cout      = c_q[LAST];
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Scoreboard bench for pipelined_addsub: 32/16 main instance plus 48/16 and 16/16 instances.
module tb_pipelined_addsub;

  localparam int W  = 32;
  localparam int C  = 16;
  localparam int ST = W / C;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n = 1'b1;
  logic         in_valid, in_ready, sub, cin, out_valid, out_ready, cout, ovf, zero;
  logic [W-1:0] a, b, sum;

  logic         iv48, ir48, sb48, ci48, ov48, or48, co48, of48, z48;
  logic [47:0]  a48, b48, s48;
  logic         iv16, ir16, sb16, ci16, ov16, or16, co16, of16, z16;
  logic [15:0]  a16, b16, s16;

  pipelined_addsub #(.WIDTH(W), .CHUNK(C)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .cin(cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf), .zero(zero));

  pipelined_addsub #(.WIDTH(48), .CHUNK(16)) u48 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv48), .in_ready(ir48),
    .a(a48), .b(b48), .sub(sb48), .cin(ci48),
    .out_valid(ov48), .out_ready(or48),
    .sum(s48), .cout(co48), .ovf(of48), .zero(z48));

  pipelined_addsub #(.WIDTH(16), .CHUNK(16)) u16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16),
    .a(a16), .b(b16), .sub(sb16), .cin(ci16),
    .out_valid(ov16), .out_ready(or16),
    .sum(s16), .cout(co16), .ovf(of16), .zero(z16));

  typedef struct packed {
    logic [W-1:0] s;
    logic         c;
    logic         o;
    logic         z;
  } exp_t;

  typedef struct packed {
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         s;
    logic         ci;
    exp_t         e;
  } vec_t;

  exp_t sb[$];
  int   out_cyc[$];
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  int   n_sent = 0;
  int   n_recv = 0;
  exp_t mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor: a result transfers on the edge after a cycle with valid && ready.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      n_recv++;
      out_cyc.push_back(cyc);
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got sum=%h with no result expected", sum);
      end else begin
        mon_e = sb.pop_front();
        if ({sum, cout, ovf, zero} !== mon_e) begin
          errors++;
          $display("FAIL sb_result: got sum=%h c=%b o=%b z=%b, want sum=%h c=%b o=%b z=%b",
                   sum, cout, ovf, zero, mon_e.s, mon_e.c, mon_e.o, mon_e.z);
        end
      end
    end
  end

  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic s, input logic ci);
    logic [W-1:0] bp;
    logic [W:0]   f;
    exp_t         e;
    bp  = s ? ~y : y;
    f   = {1'b0, x} + {1'b0, bp} + {{W{1'b0}}, (s ? 1'b1 : ci)};
    e.s = f[W-1:0];
    e.c = f[W];
    e.o = (x[W-1] == bp[W-1]) && (f[W-1] != x[W-1]);
    e.z = (f[W-1:0] == '0);
    return e;
  endfunction

  // Presents one operand set until accepted; returns the cycle number of the accepting edge.
  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                      input logic ci, input exp_t e, output int acc_cyc);
    in_valid = 1'b1; a = x; b = y; sub = s; cin = ci;
    acc_cyc = -1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready === 1'b1) begin
        sb.push_back(e);
        n_sent++;
        @(posedge clk); #1;
        acc_cyc = cyc;
        break;
      end
    end
    in_valid = 1'b0;
    if (acc_cyc < 0) begin
      checks++; errors++;
      $display("FAIL send_timeout: in_ready=%b after 50 cycles, required 1", in_ready);
    end
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 60 && sb.size() != 0; i++) @(posedge clk);
    @(posedge clk); #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d results outstanding, required 0", name, sb.size());
    end
  endtask

  task automatic test_reset();
    in_valid = 0; out_ready = 0; a = '0; b = '0; sub = 0; cin = 0;
    iv48 = 0; or48 = 1; a48 = '0; b48 = '0; sb48 = 0; ci48 = 0;
    iv16 = 0; or16 = 1; a16 = '0; b16 = '0; sb16 = 0; ci16 = 0;
    #1 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b, required 0", out_valid); end
    checks++; if (sum !== '0) begin errors++; $display("FAIL rst_sum: got %h, required 0", sum); end
    checks++; if ({cout, ovf, zero} !== 3'b000) begin errors++; $display("FAIL rst_flags: got %b, required 000", {cout, ovf, zero}); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b, required 1", in_ready); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    vec_t tbl [10];
    int   ac, k;
    tbl[0] = {32'h0000_2710, 32'h0000_006F, 1'b0, 1'b0, 32'h0000_277F, 1'b0, 1'b0, 1'b0};
    tbl[1] = {32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0001_0000, 1'b0, 1'b0, 1'b0};
    tbl[2] = {32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0};
    tbl[3] = {32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
    tbl[4] = {32'h0000_0000, 32'h0000_0001, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0};
    tbl[5] = {32'h0000_0005, 32'h0000_0005, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
    tbl[6] = {32'h0000_0001, 32'h0000_0001, 1'b0, 1'b1, 32'h0000_0003, 1'b0, 1'b0, 1'b0};
    tbl[7] = {32'h0000_000A, 32'h0000_0003, 1'b1, 1'b1, 32'h0000_0007, 1'b1, 1'b0, 1'b0};
    tbl[8] = {32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0};
    tbl[9] = {32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
    out_ready = 1'b1;
    send(tbl[0].x, tbl[0].y, tbl[0].s, tbl[0].ci, tbl[0].e, ac);
    k = 1;
    while (out_valid !== 1'b1 && k < 20) begin @(posedge clk); #1; k++; end
    checks++;
    if (k !== ST) begin errors++; $display("FAIL latency: got %0d cycles, required %0d", k, ST); end
    drain("first");
    for (int i = 1; i < 10; i++) send(tbl[i].x, tbl[i].y, tbl[i].s, tbl[i].ci, tbl[i].e, ac);
    drain("directed");
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] x, y;
    logic         s, ci;
    int           ac, first;
    first = 0;
    out_ready = 1'b1;
    out_cyc.delete();
    for (int i = 0; i < 8; i++) begin
      x = $urandom; y = $urandom;
      s = 1'($urandom_range(0, 1)); ci = 1'($urandom_range(0, 1));
      send(x, y, s, ci, model(x, y, s, ci), ac);
      if (i == 0) first = ac;
    end
    drain("b2b");
    checks++;
    if (out_cyc.size() != 8) begin
      errors++; $display("FAIL b2b_count: got %0d results, required 8", out_cyc.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (out_cyc[i] != first + ST - 1 + i) begin
          errors++;
          $display("FAIL b2b_timing: result %0d at cycle %0d, required %0d", i, out_cyc[i], first + ST - 1 + i);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [W+2:0] hold;
    int           ac;
    out_ready = 1'b0;
    send(32'h1111_2222, 32'h0F0F_0F0F, 1'b0, 1'b0, model(32'h1111_2222, 32'h0F0F_0F0F, 1'b0, 1'b0), ac);
    send(32'h9999_0000, 32'h0000_9999, 1'b1, 1'b0, model(32'h9999_0000, 32'h0000_9999, 1'b1, 1'b0), ac);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_full: out_valid=%b, required 1", out_valid); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %b, required 0", in_ready); end
    hold = {sum, cout, ovf, zero};
    a = 32'hDEAD_BEEF; b = 32'h1234_5678; sub = 1'b1; cin = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_stall_ready: cycle %0d got %b, required 0", i, in_ready); end
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_stall_valid: cycle %0d got %b, required 1", i, out_valid); end
      checks++; if ({sum, cout, ovf, zero} !== hold) begin errors++; $display("FAIL bp_hold: cycle %0d got %h, required %h", i, {sum, cout, ovf, zero}, hold); end
    end
    out_ready = 1'b1;
    send(32'h0000_0001, 32'h0000_0002, 1'b0, 1'b1, model(32'h0000_0001, 32'h0000_0002, 1'b0, 1'b1), ac);
    drain("bp");
    checks++;
    if (n_recv != n_sent) begin errors++; $display("FAIL bp_conserve: received %0d, required %0d", n_recv, n_sent); end
  endtask

  task automatic test_reset_midflight();
    int ac, stale;
    out_ready = 1'b1;
    send(32'h0000_1234, 32'h0000_0001, 1'b0, 1'b0, model(32'h0000_1234, 32'h0000_0001, 1'b0, 1'b0), ac);
    send(32'h0000_5678, 32'h0000_0001, 1'b0, 1'b0, model(32'h0000_5678, 32'h0000_0001, 1'b0, 1'b0), ac);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b, required 0", out_valid); end
    checks++; if (sum !== '0) begin errors++; $display("FAIL rstmid_sum: got %h, required 0", sum); end
    checks++; if ({cout, ovf, zero} !== 3'b000) begin errors++; $display("FAIL rstmid_flags: got %b, required 000", {cout, ovf, zero}); end
    sb.delete();
    @(negedge clk); #1 rst_n = 1'b1;
    stale = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) stale++;
    end
    checks++; if (stale != 0) begin errors++; $display("FAIL rstmid_stale: %0d cycles with out_valid, required 0", stale); end
    send(32'h00FF_00FF, 32'h0001_0001, 1'b0, 1'b0, model(32'h00FF_00FF, 32'h0001_0001, 1'b0, 1'b0), ac);
    drain("rstmid");
  endtask

  task automatic test_widths();
    int k;
    @(posedge clk); #1;
    a48 = 48'h0000_FFFF_FFFF; b48 = 48'h1; sb48 = 0; ci48 = 0; iv48 = 1;
    @(posedge clk); #1 iv48 = 0;
    k = 1;
    while (ov48 !== 1'b1 && k < 20) begin @(posedge clk); #1; k++; end
    checks++; if (k !== 3) begin errors++; $display("FAIL w48_latency: got %0d, required 3", k); end
    checks++; if (s48 !== 48'h0001_0000_0000) begin errors++; $display("FAIL w48_sum: got %h, required 000100000000", s48); end
    checks++; if (co48 !== 1'b0) begin errors++; $display("FAIL w48_cout: got %b, required 0", co48); end

    a16 = 16'hFFFF; b16 = 16'h1; sb16 = 0; ci16 = 0; iv16 = 1;
    @(posedge clk); #1 iv16 = 0;
    k = 1;
    while (ov16 !== 1'b1 && k < 20) begin @(posedge clk); #1; k++; end
    checks++; if (k !== 1) begin errors++; $display("FAIL w16_latency: got %0d, required 1", k); end
    checks++; if ({s16, co16, z16} !== {16'h0000, 1'b1, 1'b1}) begin
      errors++; $display("FAIL w16_result: got sum=%h c=%b z=%b, required sum=0000 c=1 z=1", s16, co16, z16);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_reset_midflight();
    test_widths();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
